// File: rtl/pci_target_mem_if.sv
// pci_target_mem_if: PCI control/handshake signals shared by a bus master and target devices
//   frame_n  master frame, active low
//   irdy_n   initiator ready, active low
//   cbe      command in address phase, active-low byte enables in data phase
//   devsel_n device select, active low
//   trdy_n   target ready, active low
//   stop_n   target stop request, active low
interface pci_target_mem_if;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] cbe;
    logic       devsel_n;
    logic       trdy_n;
    logic       stop_n;
    modport master (output frame_n, irdy_n, cbe, input devsel_n, trdy_n, stop_n);
    modport slave  (input frame_n, irdy_n, cbe, output devsel_n, trdy_n, stop_n);
endinterface

// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI memory-space target serving a DEPTH x 32 array over a base-aligned window
//   i_clk  bus clock, rising edge
//   i_rst  synchronous active-high reset; array contents are kept
//   bus    slave side of pci_target_mem_if (frame_n, irdy_n, cbe in; devsel_n, trdy_n, stop_n out)
//   io_ad  muxed address/data, driven only while returning read data
// PCI_TGT_BURST_EN defined: multi-phase bursts, disconnect only at the window end.
// Undefined: every transaction is single-phase with disconnect on the first data phase.
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    pci_target_mem_if.slave bus,
    inout  wire [31:0]      io_ad
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, BACKOFF, TURN, IGNORE} state_t;
    state_t        r_state, w_next;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_cnt;
    logic          r_wr;
    logic [31:0]   r_mem [DEPTH];
    logic [3:0]    w_cnt0;
    logic          w_hit, w_done, w_last, w_drive;
    assign w_hit  = io_ad[31:AW+2] == BASE_ADDR[31:AW+2] && bus.cbe[3:1] == 3'b011;
    // reads spend one extra wait cycle as the AD turnaround
    assign w_cnt0 = 4'(WAIT_STATES) + {3'b000, ~bus.cbe[0]};
`ifdef PCI_TGT_BURST_EN
    assign w_last = r_idx == AW'(DEPTH - 1);
`else
    assign w_last = 1'b1;
`endif
    assign w_done = r_state == DATA && !bus.irdy_n;
    // first read wait cycle (counter still at its load value) is the turnaround
    assign w_drive = !r_wr && (r_state == DATA || (r_state == WAIT && r_cnt != 4'(WAIT_STATES + 1)));
    assign io_ad   = w_drive ? r_mem[r_idx] : 'z;
    always_comb begin
        w_next       = r_state;
        bus.devsel_n = 1'b1;
        bus.trdy_n   = 1'b1;
        bus.stop_n   = 1'b1;
        case (r_state)
            IDLE:    if (!bus.frame_n && bus.irdy_n) w_next = !w_hit ? IGNORE : (w_cnt0 == 4'd0 ? DATA : WAIT);
            WAIT: begin
                bus.devsel_n = 1'b0;
                if (r_cnt == 4'd1) w_next = DATA;
            end
            DATA: begin
                bus.devsel_n = 1'b0;
                bus.trdy_n   = 1'b0;
                bus.stop_n   = !w_last;
                if (w_done) w_next = bus.frame_n ? TURN : (w_last ? BACKOFF : DATA);
            end
            BACKOFF: begin
                bus.devsel_n = 1'b0;
                bus.stop_n   = 1'b0;
                if (bus.frame_n) w_next = TURN;
            end
            TURN:    w_next = IDLE;
            IGNORE:  if (bus.frame_n && bus.irdy_n) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_idx <= io_ad[AW+1:2];
                r_wr  <= bus.cbe[0];
                r_cnt <= w_cnt0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_done && !w_last) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_done && r_wr)
            for (int k = 0; k < 4; k++)
                if (!bus.cbe[k]) r_mem[r_idx][8*k +: 8] <= io_ad[8*k +: 8];
    end
endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: directed bench for pci_target_mem (default WAIT_STATES=0 instance plus a WAIT_STATES=3 instance)
module tb_pci_target_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    // undriven AD reads as all ones, so a released bus is observable
    tri1 [31:0] ad;
    logic [31:0] m_ad = '0;
    logic        m_oe = 1'b0;
    assign ad = m_oe ? m_ad : 'z;
    pci_target_mem_if b1();
    pci_target_mem_if b2();
    assign b2.frame_n = b1.frame_n;
    assign b2.irdy_n  = b1.irdy_n;
    assign b2.cbe     = b1.cbe;
    pci_target_mem dut (.i_clk(clk), .i_rst(rst), .bus(b1), .io_ad(ad));
    pci_target_mem #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) dut_ws (.i_clk(clk), .i_rst(rst), .bus(b2), .io_ad(ad));
    logic sel2 = 1'b0;
    logic devsel_w, trdy_w, stop_w;
    assign devsel_w = sel2 ? b2.devsel_n : b1.devsel_n;
    assign trdy_w   = sel2 ? b2.trdy_n   : b1.trdy_n;
    assign stop_w   = sel2 ? b2.stop_n   : b1.stop_n;
`ifdef PCI_TGT_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    int          n_vec = 0, n_bad = 0;
    int          t_first, n_done, stop_ph;
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic [31:0] ad_a1, bo_ad;
    logic [2:0]  bo_out, turn_out;
    logic        dev_a1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pre(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // one transaction of up to n phases; hold_at inserts one IRDY_N=1 cycle before that phase
    task automatic xfer(input logic [31:0] addr, input logic [3:0] cmd, input int n, input logic [3:0] be, input int hold_at);
        int t;
        bit hit, bo;
        b1.frame_n = 1'b0; b1.irdy_n = 1'b1; b1.cbe = cmd; m_ad = addr; m_oe = 1'b1;
        tick();
        t = 0; t_first = -1; n_done = 0; stop_ph = -1; bo = 1'b0;
        m_oe = 1'b0; b1.cbe = be;
        for (int ph = 0; ph < n && !bo; ph++) begin
            if (ph == hold_at) begin
                b1.irdy_n = 1'b1; m_oe = 1'b0;
                tick();
                t++;
            end
            b1.irdy_n = 1'b0; b1.frame_n = (ph == n - 1); m_oe = cmd[0]; m_ad = wdata[ph];
            hit = 1'b0;
            for (int c = 0; c < 16 && !hit && !bo; c++) begin
                @(negedge clk);
                if (t == 0) begin dev_a1 = devsel_w; ad_a1 = ad; end
                if (!trdy_w) begin
                    hit = 1'b1;
                    if (t_first < 0) t_first = t + 1;
                    rdata[ph] = ad;
                    if (!stop_w) stop_ph = ph;
                end else if (!stop_w) begin
                    bo = 1'b1;
                    bo_out = {devsel_w, trdy_w, stop_w};
                    bo_ad = ad;
                end
                tick();
                t++;
            end
            if (!hit && !bo) check("trdy_timeout", {31'b0, hit}, 32'd1);
            if (hit) n_done++;
        end
        b1.irdy_n = 1'b1; m_oe = 1'b0;
        if (bo) begin
            b1.frame_n = 1'b1;
            tick();
        end
        b1.frame_n = 1'b1;
        @(negedge clk);
        turn_out = {devsel_w, trdy_w, stop_w};
        tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wdata[0] = data;
        xfer(addr, 4'b0111, 1, be, -1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        xfer(addr, 4'b0110, 1, 4'b0000, -1);
        check(tag, rdata[0], exp);
    endtask

    task automatic miss(input logic [31:0] addr, input logic [3:0] cmd);
        b1.frame_n = 1'b0; b1.irdy_n = 1'b1; b1.cbe = cmd; m_ad = addr; m_oe = 1'b1;
        tick();
        m_oe = 1'b0; b1.frame_n = 1'b1; b1.irdy_n = 1'b0; b1.cbe = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("miss_devsel", 32'(b1.devsel_n), 32'd1);
            check("miss_ad", ad, 32'hFFFF_FFFF);
            tick();
        end
        b1.irdy_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        b1.frame_n = 1'b1; b1.irdy_n = 1'b1; b1.cbe = 4'b0000;
        repeat (2) tick();
        @(negedge clk);
        check("rst_devsel", 32'(b1.devsel_n), 32'd1);
        check("rst_trdy", 32'(b1.trdy_n), 32'd1);
        check("rst_stop", 32'(b1.stop_n), 32'd1);
        check("rst_ad", ad, 32'hFFFF_FFFF);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) wr(32'h0000_FF00 + 32'(4 * i), pre(i), 4'b0000);
        // burst write with a master wait state before the third phase
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222; wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
        xfer(32'h0000_FF00, 4'b0111, 4, 4'b0000, 2);
        check("bw_phases", 32'(n_done), BURST ? 32'd4 : 32'd1);
        rd_chk("bw_rd0", 32'h0000_FF00, 32'h1111_1111);
        rd_chk("bw_rd1", 32'h0000_FF04, BURST ? 32'h2222_2222 : pre(1));
        rd_chk("bw_rd2", 32'h0000_FF08, BURST ? 32'h3333_3333 : pre(2));
        rd_chk("bw_rd3", 32'h0000_FF0C, BURST ? 32'h4444_4444 : pre(3));
        rd_chk("bw_rd4", 32'h0000_FF10, pre(4));
`ifdef PCI_TGT_BURST_EN
        xfer(32'h0000_FF00, 4'b0110, 4, 4'b0000, 1);
        check("br_phases", 32'(n_done), 32'd4);
        check("br_d0", rdata[0], 32'h1111_1111);
        check("br_d1", rdata[1], 32'h2222_2222);
        check("br_d2", rdata[2], 32'h3333_3333);
        check("br_d3", rdata[3], 32'h4444_4444);
`endif
        // window-end disconnect with FRAME_N held
        wdata[0] = 32'hC0C0_0000; wdata[1] = 32'hC1C1_0001; wdata[2] = 32'hC2C2_0002; wdata[3] = 32'hC3C3_0003;
        xfer(32'h0000_FF38, 4'b0111, 4, 4'b0000, -1);
        check("we_phases", 32'(n_done), BURST ? 32'd2 : 32'd1);
        check("we_stop_ph", 32'(stop_ph), BURST ? 32'd1 : 32'd0);
        check("we_backoff", 32'(bo_out), 32'b010);
        check("we_turn", 32'(turn_out), 32'b111);
        rd_chk("we_rd14", 32'h0000_FF38, 32'hC0C0_0000);
        rd_chk("we_rd15", 32'h0000_FF3C, BURST ? 32'hC1C1_0001 : pre(15));
        rd_chk("we_nowrap", 32'h0000_FF00, 32'h1111_1111);
        xfer(32'h0000_FF3C, 4'b0110, 2, 4'b0000, -1);
        check("re_phases", 32'(n_done), 32'd1);
        check("re_stop_ph", 32'(stop_ph), 32'd0);
        check("re_bo_ad", bo_ad, 32'hFFFF_FFFF);
        check("re_data", rdata[0], BURST ? 32'hC1C1_0001 : pre(15));
        // single write then read latency
        wr(32'h0000_FF04, 32'h0000_F0F0, 4'b0000);
        check("sw_devsel_a1", 32'(dev_a1), 32'd0);
        check("sw_trdy_lat", 32'(t_first), 32'd1);
        rd_chk("sr_data", 32'h0000_FF04, 32'h0000_F0F0);
        check("sr_trdy_lat", 32'(t_first), 32'd2);
        check("sr_turnaround", ad_a1, 32'hFFFF_FFFF);
        check("sr_turn", 32'(turn_out), 32'b111);
        // byte enables
        wr(32'h0000_FF08, 32'hFFFF_FFFF, 4'b0000);
        wr(32'h0000_FF08, 32'h1234_5678, 4'b1010);
        rd_chk("be_rd", 32'h0000_FF08, 32'hFF34_FF78);
        // reset on the edge that would complete a write
        b1.frame_n = 1'b0; b1.irdy_n = 1'b1; b1.cbe = 4'b0111; m_ad = 32'h0000_FF14; m_oe = 1'b1;
        tick();
        b1.frame_n = 1'b1; b1.irdy_n = 1'b0; b1.cbe = 4'b0000; m_ad = 32'hDEAD_BEEF; rst = 1'b1;
        tick();
        rst = 1'b0; b1.irdy_n = 1'b1; m_oe = 1'b0;
        @(negedge clk);
        check("rstmid_out", 32'({b1.devsel_n, b1.trdy_n, b1.stop_n}), 32'b111);
        tick();
        rd_chk("rstmid_nocommit", 32'h0000_FF14, pre(5));
        // decode misses
        miss(32'h0001_0000, 4'b0110);
        miss(32'h0000_FF00, 4'b1010);
        // three wait states
        sel2 = 1'b1;
        wr(32'h0000_1004, 32'h5A5A_1234, 4'b0000);
        check("ws_wr_lat", 32'(t_first), 32'd4);
        rd_chk("ws_rd_data", 32'h0000_1004, 32'h5A5A_1234);
        check("ws_rd_lat", 32'(t_first), 32'd5);
        sel2 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
